// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem request at a time, holds the fetched word for decode.
// Optional IFU_PERF_CNT_EN adds fetch/stall performance counters.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;

  logic        w_consume;
  logic        w_stall;

  // A consume only counts when no redirect steals the HOLD->REQ transition.
  assign w_consume = (r_state == HOLD) && inst_ready_i && !jump_flag_i;
  assign w_stall   = (r_state == WAIT) || ((r_state == REQ) && !imem_req_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= INST_NOP;
      r_inst_addr  <= RESET_PC;
    end else begin
      case (r_state)
        REQ: begin
          if (jump_flag_i) begin
            r_pc <= jump_addr_i;
            if (imem_req_ready_i) begin
              r_kill  <= 1'b1;
              r_state <= WAIT;
            end
          end else if (imem_req_ready_i) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (jump_flag_i) begin
            r_pc <= jump_addr_i;
            if (imem_resp_valid_i) begin
              r_kill  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_kill  <= 1'b1;
            end
          end else if (imem_resp_valid_i) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_inst       <= imem_resp_data_i;
              r_inst_addr  <= r_pc;
              r_inst_valid <= 1'b1;
              r_state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (jump_flag_i) begin
            r_pc         <= jump_addr_i;
            r_inst_valid <= 1'b0;
            r_state      <= REQ;
          end else if (inst_ready_i) begin
            r_pc         <= r_pc + 32'd4;
            r_inst_valid <= 1'b0;
            r_state      <= REQ;
          end
        end
        default: begin
          r_inst_valid <= 1'b0;
          r_state      <= REQ;
        end
      endcase
    end
  end

  assign imem_req_valid_o = (r_state == REQ);
  assign imem_req_addr_o  = r_pc;
  assign inst_valid_o     = r_inst_valid;
  assign inst_o           = r_inst_valid ? r_inst : INST_NOP;
  assign inst_addr_o      = r_inst_addr;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`else
  logic w_perf_unused;
  assign w_perf_unused = w_consume ^ w_stall;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the fetch unit: handshakes, back-pressure, redirects, reset, optional counters.
module tb_ysyx_23060332_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_23060332_ifu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o  (perf_fetch_cnt_o),
    .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = 32'h0;
    inst_ready_i      = 1'b0;
    jump_flag_i       = 1'b0;
    jump_addr_i       = 32'h0;

    #12;
    chk1 ("rst_inst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst",       inst_o,       32'h0000_0013);
    chk32("rst_inst_addr",  inst_addr_o,  32'h8000_0000);
    chk32("rst_req_addr",   imem_req_addr_o, 32'h8000_0000);
    rst_n = 1'b1;
    chk1 ("t1_req_valid",   imem_req_valid_o, 1'b1);

    // Zero-wait fetch with decode always ready.
    imem_req_ready_i = 1'b1;
    inst_ready_i     = 1'b1;
    step();
    chk1 ("t1_wait_req_valid", imem_req_valid_o, 1'b0);
    chk1 ("t1_wait_inst_valid", inst_valid_o, 1'b0);
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0010_0093;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t1_hold_valid", inst_valid_o, 1'b1);
    chk32("t1_hold_inst",  inst_o,       32'h0010_0093);
    chk32("t1_hold_addr",  inst_addr_o,  32'h8000_0000);
    step();
    chk1 ("t1_after_valid", inst_valid_o, 1'b0);
    chk32("t1_after_inst",  inst_o,       32'h0000_0013);
    chk1 ("t1_next_req",    imem_req_valid_o, 1'b1);
    chk32("t1_next_addr",   imem_req_addr_o,  32'h8000_0004);
    imem_req_ready_i = 1'b1;
    step();
    chk1 ("t1_bubble2", inst_valid_o, 1'b0);
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0000_0113;
    inst_ready_i      = 1'b0;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t1_second_valid", inst_valid_o, 1'b1);
    chk32("t1_second_inst",  inst_o,       32'h0000_0113);
    chk32("t1_second_addr",  inst_addr_o,  32'h8000_0004);

    // Decode back-pressure: nothing moves and no request goes out.
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1 ("t2_valid",   inst_valid_o,     1'b1);
      chk32("t2_inst",    inst_o,           32'h0000_0113);
      chk32("t2_addr",    inst_addr_o,      32'h8000_0004);
      chk1 ("t2_no_req",  imem_req_valid_o, 1'b0);
    end
    inst_ready_i     = 1'b1;
    imem_req_ready_i = 1'b0;
    step();
    chk1 ("t2_req",      imem_req_valid_o, 1'b1);
    chk32("t2_req_addr", imem_req_addr_o,  32'h8000_0008);
    chk1 ("t2_cleared",  inst_valid_o,     1'b0);

    // Redirect in WAIT; the in-flight response arrives three cycles later.
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h8000_0100;
    step();
    jump_flag_i = 1'b0;
    chk1 ("t3_still_wait", imem_req_valid_o, 1'b0);
    step();
    step();
    chk1 ("t3_still_wait2", imem_req_valid_o, 1'b0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t3_dropped",  inst_valid_o,     1'b0);
    chk32("t3_dropped_inst", inst_o,       32'h0000_0013);
    chk1 ("t3_req",      imem_req_valid_o, 1'b1);
    chk32("t3_req_addr", imem_req_addr_o,  32'h8000_0100);

    // Redirect in HOLD coincident with decode ready.
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0020_0193;
    inst_ready_i      = 1'b0;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t4_hold_valid", inst_valid_o, 1'b1);
    chk32("t4_hold_addr",  inst_addr_o,  32'h8000_0100);
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h8000_0200;
    inst_ready_i = 1'b1;
    step();
    jump_flag_i = 1'b0;
    chk1 ("t4_dropped",  inst_valid_o,     1'b0);
    chk32("t4_nop",      inst_o,           32'h0000_0013);
    chk1 ("t4_req",      imem_req_valid_o, 1'b1);
    chk32("t4_req_addr", imem_req_addr_o,  32'h8000_0200);

    // Redirect in REQ without acceptance; unaligned target passes through.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h8000_0302;
    step();
    jump_flag_i = 1'b0;
    chk1 ("req_jump_stay", imem_req_valid_o, 1'b1);
    chk32("req_jump_addr", imem_req_addr_o,  32'h8000_0302);

    // Redirect in REQ coincident with acceptance: stale response is killed.
    jump_flag_i      = 1'b1;
    jump_addr_i      = 32'h8000_0400;
    imem_req_ready_i = 1'b1;
    step();
    jump_flag_i      = 1'b0;
    imem_req_ready_i = 1'b0;
    chk1 ("req_kill_wait", imem_req_valid_o, 1'b0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hBAD0_0001;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("req_kill_drop", inst_valid_o,     1'b0);
    chk1 ("req_kill_req",  imem_req_valid_o, 1'b1);
    chk32("req_kill_addr", imem_req_addr_o,  32'h8000_0400);

    // Redirect in WAIT coincident with the response.
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    jump_flag_i       = 1'b1;
    jump_addr_i       = 32'hFFFF_FFFC;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hBAD0_0002;
    step();
    jump_flag_i       = 1'b0;
    imem_resp_valid_i = 1'b0;
    chk1 ("wait_coinc_drop", inst_valid_o,     1'b0);
    chk1 ("wait_coinc_req",  imem_req_valid_o, 1'b1);
    chk32("wait_coinc_addr", imem_req_addr_o,  32'hFFFF_FFFC);

    // Fetch at the top of the address space, then wrap on consume.
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0030_0213;
    inst_ready_i      = 1'b1;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("wrap_valid", inst_valid_o, 1'b1);
    chk32("wrap_inst",  inst_o,       32'h0030_0213);
    chk32("wrap_iaddr", inst_addr_o,  32'hFFFF_FFFC);
    step();
    chk1 ("wrap_req",   imem_req_valid_o, 1'b1);
    chk32("wrap_addr",  imem_req_addr_o,  32'h0000_0000);

    // Asynchronous reset while waiting for a response.
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk1 ("t5_wait", imem_req_valid_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("t5_req_valid",  imem_req_valid_o, 1'b1);
    chk32("t5_req_addr",   imem_req_addr_o,  32'h8000_0000);
    chk1 ("t5_inst_valid", inst_valid_o,     1'b0);
    chk32("t5_inst",       inst_o,           32'h0000_0013);
    chk32("t5_inst_addr",  inst_addr_o,      32'h8000_0000);
    step();
    rst_n = 1'b1;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hBAD0_0003;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t5_late_ignored", inst_valid_o,     1'b0);
    chk1 ("t5_late_req",     imem_req_valid_o, 1'b1);
    chk32("t5_late_addr",    imem_req_addr_o,  32'h8000_0000);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0010_0093;
    step();
    imem_resp_valid_i = 1'b0;
    chk1 ("t5_refetch_valid", inst_valid_o, 1'b1);
    chk32("t5_refetch_inst",  inst_o,       32'h0010_0093);
    chk32("t5_refetch_addr",  inst_addr_o,  32'h8000_0000);

`ifdef IFU_PERF_CNT_EN
    // Three fetches with two WAIT cycles each: 3 fetches, 6 stall cycles.
    rst_n = 1'b0;
    #1;
    chk32("t6_fetch_rst", perf_fetch_cnt_o, 32'd0);
    chk32("t6_stall_rst", perf_stall_cnt_o, 32'd0);
    step();
    rst_n        = 1'b1;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_req_ready_i = 1'b1;
      step();
      imem_req_ready_i = 1'b0;
      step();
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = 32'h0000_1000 + i;
      step();
      imem_resp_valid_i = 1'b0;
      chk32("t6_inst", inst_o, 32'h0000_1000 + i);
      step();
    end
    chk32("t6_fetch_cnt", perf_fetch_cnt_o, 32'd3);
    chk32("t6_stall_cnt", perf_stall_cnt_o, 32'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
